// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side handshake between the UART receiver and the
// UART buffer.
//   rx_ready  - one-cycle strobe: a new byte is valid on rx_data
//   rx_data   - last good byte, held between strobes
//   frame_err - one-cycle strobe: a frame ended with a low stop bit
// Modports: master = the receiver (drives), slave = the consumer (samples).
interface uart_rx_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       frame_err;

    modport master (output rx_ready, output rx_data, output frame_err);
    modport slave  (input  rx_ready, input  rx_data, input  frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first.
// The asynchronous rx pin passes through a two-flop synchronizer. A per-bit
// cycle counter places three samples around mid-bit, and the majority of
// those samples decides each bit value. A good byte is presented with a
// one-cycle rx_ready strobe. A low stop bit gives a one-cycle frame_err
// strobe and leaves rx_data unchanged.
// Ports:
//   clk    - system clock, posedge
//   rst_n  - asynchronous active-low reset
//   rx     - asynchronous serial input, idle high
//   rx_bus - uart_rx_if.master: rx_ready / rx_data / frame_err
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    uart_rx_if.master   rx_bus
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SMP_0    = CW'(H - 1);
    localparam logic [CW-1:0] SMP_1    = CW'(H);
    localparam logic [CW-1:0] SMP_DEC  = CW'(H + 1);

    typedef enum logic [2:0] {
        HUNT,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic          s1_reg, s2_reg;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          samp_a_reg, samp_a_next;
    logic          samp_b_reg, samp_b_next;
    logic          rx_ready_reg, rx_ready_next;
    logic          frame_err_reg, frame_err_next;
    logic [7:0]    rx_data_reg, rx_data_next;

    logic rx_s;
    logic maj;
    logic cnt_wrap;
    logic decide;
    logic [CW-1:0] cnt_inc;

    assign rx_s     = s2_reg;
    // The third sample is the live synchronized line at the decision point.
    assign maj      = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s) | (samp_b_reg & rx_s);
    assign cnt_wrap = (cnt_reg == CNT_LAST);
    assign decide   = (cnt_reg == SMP_DEC);
    assign cnt_inc  = cnt_wrap ? '0 : cnt_reg + CW'(1);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        rx_data_next   = rx_data_reg;
        rx_ready_next  = 1'b0;
        frame_err_next = 1'b0;
        samp_a_next    = (cnt_reg == SMP_0) ? rx_s : samp_a_reg;
        samp_b_next    = (cnt_reg == SMP_1) ? rx_s : samp_b_reg;

        case (state_reg)
            // Refuses to arm until the line has actually been seen high.
            HUNT: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            // Decision and wrap may coincide for small CLKS_PER_BIT, so the
            // false-start check takes priority over the wrap.
            START: begin
                cnt_next = cnt_inc;
                if (decide && maj) begin
                    state_next = HUNT;
                    cnt_next   = '0;
                end else if (cnt_wrap) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                cnt_next = cnt_inc;
                if (decide) begin
                    shift_next = {maj, shift_reg[7:1]};
                end
                if (cnt_wrap) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            // Leaves at the decision point so a start edge right after the
            // stop bit is still caught by IDLE.
            STOP: begin
                cnt_next = cnt_inc;
                if (decide) begin
                    cnt_next = '0;
                    if (maj) begin
                        rx_data_next  = shift_reg;
                        rx_ready_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = HUNT;
                    end
                end
            end
            default: begin
                state_next = HUNT;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg        <= 1'b0;
            s2_reg        <= 1'b0;
            state_reg     <= HUNT;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            samp_a_reg    <= 1'b0;
            samp_b_reg    <= 1'b0;
            rx_ready_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            rx_data_reg   <= '0;
        end else begin
            s1_reg        <= rx;
            s2_reg        <= s1_reg;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            samp_a_reg    <= samp_a_next;
            samp_b_reg    <= samp_b_next;
            rx_ready_reg  <= rx_ready_next;
            frame_err_reg <= frame_err_next;
            rx_data_reg   <= rx_data_next;
        end
    end

    assign rx_bus.rx_ready  = rx_ready_reg;
    assign rx_bus.frame_err = frame_err_reg;
    assign rx_bus.rx_data   = rx_data_reg;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// Frames are driven with exact 16-cycle bit periods. For every frame the
// bench predicts one event: the strobe kind, the edge it occurs on (first
// low-sampling edge + 9N + H + 4) and the rx_data value seen with it.
// A monitor records every observed strobe for comparison.
module tb_uart_rx;
    localparam int N   = 16;
    localparam int H   = N / 2;
    localparam int LAT = 9 * N + H + 4;

    typedef struct {
        int         cyc;
        int         kind;   // 1 = rx_ready, 2 = frame_err, 3 = both
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx     (rx),
        .rx_bus (bus)
    );

    always #5 clk = ~clk;

    int         pe = 0;
    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;
    int         data_glitch = 0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) pe <= pe + 1;

    always @(negedge clk) begin
        if (bus.rx_ready || bus.frame_err) begin
            obs_q.push_back('{pe, int'(bus.rx_ready) + 2 * int'(bus.frame_err), bus.rx_data});
        end
        if (rst_n && !bus.rx_ready && bus.rx_data !== prev_data) begin
            data_glitch <= data_glitch + 1;
        end
        prev_data <= bus.rx_data;
    end

    // Hold the line at val for n clock cycles; called just after a negedge.
    task automatic hold(input logic val, input int n);
        rx = val;
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame. inv flips the line for the one cycle that lands on
    // the middle sample of each bit. rst_bit >= 0 pulses reset during that
    // data bit and abandons the frame.
    task automatic drive_frame(input logic [7:0] b, input logic stop_v,
                               input logic inv, input int rst_bit);
        int   e0;
        logic bv;
        e0 = pe + 1;
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      bv = 1'b0;
            else if (j == 9) bv = stop_v;
            else             bv = b[j-1];
            for (int m = 0; m < 16; m++) begin
                rx = (inv && m == 9) ? ~bv : bv;
                if (rst_bit >= 0 && j == rst_bit + 1 && m == 4) begin
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if (bus.rx_ready !== 1'b0 || bus.frame_err !== 1'b0 || bus.rx_data !== 8'h00) begin
                        errors++;
                        $display("FAIL async_reset: got rdy=%b err=%b data=%02h want 0 0 00",
                                 bus.rx_ready, bus.frame_err, bus.rx_data);
                    end
                end
                if (rst_bit >= 0 && j == rst_bit + 1 && m == 7) rst_n = 1'b1;
                @(negedge clk);
            end
        end
        if (rst_bit >= 0) begin
            last_good = 8'h00;
        end else if (stop_v) begin
            last_good = b;
            exp_q.push_back('{e0 + LAT, 1, b});
        end else begin
            exp_q.push_back('{e0 + LAT, 2, last_good});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.rx_ready !== 1'b0) begin
            errors++; $display("FAIL reset_rx_ready: got %b want 0", bus.rx_ready);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err);
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_rx_data: got %02h want 00", bus.rx_data);
        end
        $display("reset: rdy=%b err=%b data=%02h", bus.rx_ready, bus.frame_err, bus.rx_data);
    endtask

    task automatic test_low_after_reset();
        rst_n = 1'b1;
        hold(1'b0, 100);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL low_line_quiet: got %0d strobes want 0", obs_q.size());
        end
        hold(1'b1, 32);
        drive_frame(8'hA5, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL low_after_reset_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            $display("low_after_reset ev%0d: cyc=%0d kind=%0d data=%02h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data);
            if (obs_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL low_after_reset_ev%0d: got cyc=%0d kind=%0d data=%02h want cyc=%0d kind=%0d data=%02h",
                         i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        drive_frame(8'h00, 1'b1, 1'b0, -1);
        drive_frame(8'hFF, 1'b1, 1'b0, -1);
        drive_frame(8'h55, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL back_to_back_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            $display("back_to_back ev%0d: cyc=%0d kind=%0d data=%02h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data);
            if (obs_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL back_to_back_ev%0d: got cyc=%0d kind=%0d data=%02h want cyc=%0d kind=%0d data=%02h",
                         i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
            if (i > 0) begin
                checks++;
                if (obs_q[i].cyc - obs_q[i-1].cyc != 10 * N) begin
                    errors++;
                    $display("FAIL back_to_back_spacing%0d: got %0d want %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, 10 * N);
                end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_framing();
        drive_frame(8'h3C, 1'b0, 1'b0, -1);
        hold(1'b0, 50);
        hold(1'b1, 32);
        drive_frame(8'h7E, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL framing_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            $display("framing ev%0d: cyc=%0d kind=%0d data=%02h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data);
            if (obs_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL framing_ev%0d: got cyc=%0d kind=%0d data=%02h want cyc=%0d kind=%0d data=%02h",
                         i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        hold(1'b0, 5);
        hold(1'b1, 40);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL glitch_quiet: got %0d strobes want 0", obs_q.size());
        end
        drive_frame(8'h3C, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL glitch_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            $display("glitch ev%0d: cyc=%0d kind=%0d data=%02h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data);
            if (obs_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL glitch_ev%0d: got cyc=%0d kind=%0d data=%02h want cyc=%0d kind=%0d data=%02h",
                         i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_majority();
        drive_frame(8'h81, 1'b1, 1'b1, -1);
        hold(1'b1, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL majority_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            $display("majority ev%0d: cyc=%0d kind=%0d data=%02h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data);
            if (obs_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL majority_ev%0d: got cyc=%0d kind=%0d data=%02h want cyc=%0d kind=%0d data=%02h",
                         i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        drive_frame(8'hC3, 1'b1, 1'b0, 3);
        hold(1'b1, 32);
        drive_frame(8'h96, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL reset_midframe_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            $display("reset_midframe ev%0d: cyc=%0d kind=%0d data=%02h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data);
            if (obs_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL reset_midframe_ev%0d: got cyc=%0d kind=%0d data=%02h want cyc=%0d kind=%0d data=%02h",
                         i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_v;
        for (int t = 0; t < 10; t++) begin
            b      = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 3) != 0);
            hold(1'b1, $urandom_range(2, 20));
            drive_frame(b, stop_v, 1'b0, -1);
        end
        hold(1'b1, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            $display("random ev%0d: cyc=%0d kind=%0d data=%02h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data);
            if (obs_q[i] != exp_q[i]) begin
                errors++;
                $display("FAIL random_ev%0d: got cyc=%0d kind=%0d data=%02h want cyc=%0d kind=%0d data=%02h",
                         i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
        end
        obs_q.delete(); exp_q.delete();
        checks++;
        if (data_glitch != 0) begin
            errors++; $display("FAIL rx_data_held: got %0d changes without rx_ready want 0", data_glitch);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b0;
        @(negedge clk);
        test_reset();
        test_low_after_reset();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_majority();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path. It samples the asynchronous `rx` pin with a two-flop synchronizer and recovers 8N1 frames (LSB first) using a per-bit cycle counter and 3-sample majority voting. For each good byte it presents the byte on `rx_data` with a one-cycle `rx_ready` strobe, which is the handshake the UART buffer interface consumes. Framing errors are flagged on `frame_err` and never produce `rx_ready`.

## Interface
- `CLKS_PER_BIT`, 104, clk cycles per bit time (N). Legal range ≥ 4. H = N/2, integer division.
- `clk` in 1 system clock; all logic on posedge.
- `rst_n` in 1 reset, asynchronous and active-low.
- `rx` in 1 serial line, asynchronous; idle high.
- `rx_ready` out 1 one-cycle strobe: a new byte is valid on `rx_data`.
- `rx_data` out 8 last good byte; updated only together with `rx_ready`, held otherwise.
- `frame_err` out 1 one-cycle strobe: the stop bit sampled low.

## Operation
- Synchronizer: `rx` → s1 → s2 (= rx_s). Both flops reset to 0, so the line must actually be seen high before any frame is armed.
- The per-bit counter `cnt` counts 0..N-1 and wraps to 0 at N-1; the bit index advances on the wrap.
- Sample points are cnt = H-1, H and H+1. The bit value is the majority of the three rx_s samples, decided at cnt = H+1.
- The FSM has five states:
  - HUNT (reset state): stay while rx_s = 0. When rx_s = 1, go to IDLE.
  - IDLE: when rx_s = 0, go to START with cnt = 0.
  - START: at the decision point, majority 1 is a false start and returns to HUNT with no strobe. Majority 0 continues; at cnt = N-1, go to DATA with bit index 0.
  - DATA: at each decision point, shift the majority bit into the shift register LSB-first. At cnt = N-1 on bit 7, go to STOP; otherwise increment the bit index.
  - STOP: at the decision point, majority 1 registers the shift register into `rx_data` and pulses `rx_ready`, then goes to IDLE immediately without waiting for the rest of the stop bit. Majority 0 pulses `frame_err`, leaves `rx_data` unchanged and goes to HUNT, which absorbs a break or a stuck-low line.
- `rx_ready` and `frame_err` are mutually exclusive and are never asserted on consecutive cycles for one frame.
- Back-to-back frames: IDLE is re-entered N-H-2 cycles before the nominal end of the stop bit, so a start edge immediately after the stop bit is caught.
- Reset mid-frame: the frame is abandoned and no strobe is produced. After release the block sits in HUNT until the line is high, so a frame in progress is never decoded.

## Timing
- Reset values: `rx_ready` = 0, `frame_err` = 0, `rx_data` = 8'h00, s1 = s2 = 0, `cnt` = 0, bit index = 0, shift register = 0, state HUNT.
- E0 is the first posedge that samples `rx` low. rx_s is low in the cycle after E1, and START is entered at E2 (cnt = 0 in the cycle starting at E2).
- In frame cycle k after E2, the data bit i decision is at k = N(1+i) + H+1, and the stop decision is at k = 9N + H+1.
- `rx_ready` or `frame_err` is high for exactly the cycle starting at edge E0 + 9N + H + 4. For N = 104 this is E0 + 992; for N = 16 it is E0 + 156.
- `rx_data` changes at the same edge that raises `rx_ready` and is stable afterwards until the next good frame.
- The minimum spacing of `rx_ready` strobes for continuous traffic is 10N cycles.
- Downstream requirement: the consumer latches `rx_data` while `rx_ready` = 1. Its busy time must be under 10N cycles; this block has no backpressure and no overrun flag.

## Test plan
All scenarios use N = 16 (H = 8) with bit periods of exactly 16 clk cycles.
- Hold `rx` low through reset and for 100 cycles after release, then high for 32 cycles, then send 0xA5. Required: no strobe while the line is low; `rx_ready` for one cycle at E0+156 with `rx_data` = 0xA5.
- Send 0x00, 0xFF, 0x55 back-to-back with no idle gap. Required: three `rx_ready` pulses spaced 160 cycles apart carrying 0x00, 0xFF, 0x55; `frame_err` never asserts.
- Drive a 5-cycle low glitch on an idle line, then send 0x3C after 40 cycles. Required: no strobe for the glitch; `rx_ready` with `rx_data` = 0x3C for the real frame.
- Send 0x3C with the stop bit driven low, then hold low for 50 cycles, then idle, then send 0x7E. Required: `frame_err` for one cycle at E0+156 with `rx_ready` = 0 and `rx_data` still holding the prior byte; nothing during the break; then `rx_ready` with `rx_data` = 0x7E.
- Send 0x81 with a one-cycle inversion at cnt = H in every bit. Required: `rx_ready` with `rx_data` = 0x81, because the majority vote masks each inversion.
- Assert `rst_n` low for 3 cycles during data bit 3 of 0xC3, then send 0x96 after the line idles. Required: outputs go to their reset values asynchronously; no strobe for 0xC3; `rx_ready` with `rx_data` = 0x96.
